flag_event_queue: RTL and testbench
===================================

Name: flag_event_queue

Overview:
- Destination-domain consumer of single-cycle event flags produced by the flag clock-domain crossing.
- Captures a data word on each flag pulse into a small FIFO and presents events to downstream logic (voice allocator, MIDI handler) over a valid/ready handshake.
- Counts and reports events lost to a full queue, so bursts of crossed events are never silently merged.

Parameters:
- DATA_W, 8, width of the event data word.
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; the destination domain of the flag crossing.
- rst_n  in  1  asynchronous active-low reset.
- flag_in  in  1  single-cycle event pulse from the flag crossing output.
- data_in  in  DATA_W  event payload; the source holds it stable for the cycle flag_in is high.
- out_valid  out  1  queue non-empty; head entry available.
- out_data  out  DATA_W  head entry; valid only while out_valid=1.
- out_ready  in  1  consumer accepts the head entry when out_valid & out_ready.
- level  out  $clog2(DEPTH)+1  current number of stored entries, 0..DEPTH.
- overflow  out  1  sticky flag; set when an event is dropped.
- drop_cnt  out  CNT_W  saturating count of dropped events.
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0.
  - Read and write pointers are 0.
  - Storage contents are don't-care but read as 0 after reset.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits, with the extra bit as the wrap flag.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Wrap-around is natural binary rollover.
- Push is (flag_in=1) & (!full | pop).
  - A push while full is accepted when a pop occurs in the same cycle.
  - On push, data_in is written at wr_ptr and wr_ptr increments.
- Pop is out_valid & out_ready; rd_ptr increments. out_ready while empty has no effect.
- The queue is first-word fall-through:
  - out_data = storage[rd_ptr] combinationally from the register array.
  - out_valid = !empty.
- Latency: flag_in high in cycle n into an empty queue gives out_valid=1 and out_data=data_in(n) from cycle n+1.
- Simultaneous push and pop:
  - level unchanged.
  - On an empty queue no pop is possible, so only the push takes effect.
- level = wr_ptr - rd_ptr (modular). It is updated in the same edge as the pointers.
- Drop: flag_in=1 & full & !pop.
  - The event is discarded and storage is untouched.
  - overflow is set to 1.
  - drop_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- clr_ovf=1: overflow<=0 and drop_cnt<=0.
  - If a drop occurs in the same cycle, the drop wins for that event: overflow<=1, drop_cnt<=1.
- Order: events leave in arrival order; no reordering, no merging.
- No state machine beyond the pointers. All state is updated on posedge clk and cleared only by rst_n.
- Reset mid-operation: queued events are lost, all outputs return to reset values immediately, and flag_in is ignored while rst_n=0.

Decomposition:
- Shared package flag_evt_pkg holds:
  - default DATA_W/DEPTH/CNT_W constants;
  - the PTR_W function ($clog2(DEPTH)+1);
  - CNT_MAX.
- One natural sub-module: evt_fifo_core, containing storage, pointers, full/empty and level.
- The top level adds push/drop qualification, the overflow flag and the saturating counter.

Test Plan:
1. Single event: reset, pulse flag_in with data_in=0x3C, out_ready=0. Required: out_valid=1 and out_data=0x3C from the next cycle, level=1. Then out_ready=1 for 1 cycle: out_valid=0, level=0.
2. Fill and order: 4 pulses with data 0x01..0x04 and out_ready=0. Required: level=4 (full). Drain: out_data reads 0x01,0x02,0x03,0x04 in order, then out_valid=0.
3. Overflow: with the queue full, 3 more pulses and no pop. Required: queue contents unchanged, overflow=1, drop_cnt=3. Then clr_ovf for 1 cycle: overflow=0, drop_cnt=0.
4. Full push+pop: with the queue full, flag_in with data 0xAA and out_ready=1 in the same cycle. Required: no drop, level stays 4, 0xAA emerges last after draining.
5. Saturation and clear race: CNT_W=2, 5 drops. Required: drop_cnt=3 (held, no wrap). Then a drop in the same cycle as clr_ovf: overflow=1, drop_cnt=1.
6. Reset mid-operation: 2 queued entries, assert rst_n=0 between clock edges. Required: out_valid=0, level=0 and overflow=0 immediately, without waiting for a clock edge. After release, a new pulse with 0x55 gives out_data=0x55.

Source files
------------

// File: rtl/flag_event_queue_pkg.sv
// Shared constants and sizing helpers for the flag event queue.
package flag_evt_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_CNT_W  = 8;

  // Pointer width: address bits plus one wrap bit, so full and empty can be told apart.
  function automatic int ptrW(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Largest value a CNT_W-bit saturating counter may hold.
  function automatic int cntMax(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX = cntMax(DEF_CNT_W);

endpackage

// File: rtl/flag_event_queue_if.sv
// Valid/ready event stream between the queue and its downstream consumer.
interface flag_event_queue_if #(
  parameter int DATA_W = 8
);
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/flag_event_queue_fifo.sv
// evt_fifo_core: register-array FIFO with wrap-bit pointers, first-word fall-through read.
module evt_fifo_core
  import flag_evt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wrData,
  output logic [DATA_W-1:0]      rdData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = ptrW(DEPTH);
  localparam int AW = PW - 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                wrPtr;
  logic [PW-1:0]                rdPtr;

  // Storage is cleared on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (push) begin
      mem[wrPtr[AW-1:0]] <= wrData;
    end
  end

  // Pointers roll over naturally; the top bit flags an odd number of wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Status and head data are derived combinationally from the pointers.
  always_comb begin
    empty  = (wrPtr == rdPtr);
    full   = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    level  = wrPtr - rdPtr;
    rdData = mem[rdPtr[AW-1:0]];
  end

endmodule

// File: rtl/flag_event_queue.sv
// flag_event_queue: captures data on each crossed flag pulse, queues it, and
// counts events lost to a full queue.
module flag_event_queue
  import flag_evt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flag_in,
  input  logic [DATA_W-1:0]      data_in,
  flag_event_queue_if.master     evIf,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic                   clr_ovf
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(cntMax(CNT_W));

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // A full queue still accepts an event when the head leaves in the same cycle.
  always_comb begin
    pop  = !empty && evIf.out_ready;
    push = flag_in && (!full || pop);
    drop = flag_in && full && !pop;
  end

  assign evIf.out_valid = !empty;

  evt_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) uFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wrData (data_in),
    .rdData (evIf.out_data),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // Sticky overflow and saturating drop count; a drop coinciding with a clear
  // is recorded as the first event after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                drop_cnt <= CNT_W'(1);
      else if (drop_cnt != CNT_TOP) drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_flag_event_queue.sv
// Bench for flag_event_queue: directed stimulus, scoreboard queue of expected
// output words, and a monitor that checks every accepted head entry.
module tb_flag_event_queue;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int CW = 2;
  localparam int LW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flag_in = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [LW-1:0] level;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  flag_event_queue_if #(.DATA_W(DW)) evIf ();

  flag_event_queue #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag_in  (flag_in),
    .data_in  (data_in),
    .evIf     (evIf),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] expQ[$];

  // Monitor: every handshake observed mid-cycle must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && evIf.out_valid && evIf.out_ready) begin
      logic [DW-1:0] e;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got=%h expected none", evIf.out_data);
      end else begin
        e = expQ.pop_front();
        if (evIf.out_data !== e) begin
          failures++;
          $display("FAIL pop_data got=%h expected=%h", evIf.out_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, ex);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse one event; accepted events are queued as expected output.
  task automatic pulse(input logic [DW-1:0] d, input bit accepted);
    flag_in = 1'b1;
    data_in = d;
    if (accepted) expQ.push_back(d);
    tick();
    flag_in = 1'b0;
  endtask

  task automatic drain(input int n);
    evIf.out_ready = 1'b1;
    repeat (n) tick();
    evIf.out_ready = 1'b0;
  endtask

  initial begin
    evIf.out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(evIf.out_valid), 0);
    chk("rst_data", 32'(evIf.out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_cnt", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Single event, one-cycle latency, then consume it.
    pulse(8'h3C, 1'b1);
    chk("t1_valid", 32'(evIf.out_valid), 1);
    chk("t1_data", 32'(evIf.out_data), 32'h3C);
    chk("t1_level", 32'(level), 1);
    drain(1);
    chk("t1_valid_after", 32'(evIf.out_valid), 0);
    chk("t1_level_after", 32'(level), 0);

    // Fill and drain in order.
    for (int i = 1; i <= 4; i++) pulse(DW'(i), 1'b1);
    chk("t2_level_full", 32'(level), 4);
    chk("t2_head", 32'(evIf.out_data), 32'h01);
    drain(4);
    chk("t2_valid_empty", 32'(evIf.out_valid), 0);
    chk("t2_level_empty", 32'(level), 0);

    // Overflow: three drops while full, then clear.
    for (int i = 0; i < 4; i++) pulse(DW'(8'h11 + i), 1'b1);
    for (int i = 0; i < 3; i++) pulse(DW'(8'hE0 + i), 1'b0);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_cnt", 32'(drop_cnt), 3);
    chk("t3_level", 32'(level), 4);
    chk("t3_head", 32'(evIf.out_data), 32'h11);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);
    chk("t3_cnt_clr", 32'(drop_cnt), 0);

    // Push while full is accepted when the head leaves the same cycle.
    evIf.out_ready = 1'b1;
    pulse(8'hAA, 1'b1);
    evIf.out_ready = 1'b0;
    chk("t4_level", 32'(level), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_cnt", 32'(drop_cnt), 0);
    drain(4);
    chk("t4_valid_empty", 32'(evIf.out_valid), 0);

    // Saturation of the 2-bit counter, then drop racing a clear.
    for (int i = 0; i < 4; i++) pulse(DW'(8'h21 + i), 1'b1);
    for (int i = 0; i < 5; i++) pulse(8'hF0, 1'b0);
    chk("t5_cnt_sat", 32'(drop_cnt), 3);
    chk("t5_ovf", 32'(overflow), 1);
    clr_ovf = 1'b1;
    pulse(8'hF1, 1'b0);
    clr_ovf = 1'b0;
    chk("t5_race_ovf", 32'(overflow), 1);
    chk("t5_race_cnt", 32'(drop_cnt), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t5_clr_cnt", 32'(drop_cnt), 0);
    drain(4);

    // Reset mid-operation takes effect without a clock edge.
    pulse(8'h31, 1'b1);
    pulse(8'h32, 1'b1);
    chk("t6_level_pre", 32'(level), 2);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    chk("t6_valid_rst", 32'(evIf.out_valid), 0);
    chk("t6_level_rst", 32'(level), 0);
    chk("t6_ovf_rst", 32'(overflow), 0);
    flag_in = 1'b1;
    data_in = 8'h99;
    tick();
    flag_in = 1'b0;
    chk("t6_level_ignored", 32'(level), 0);
    #2;
    rst_n = 1'b1;
    tick();
    pulse(8'h55, 1'b1);
    chk("t6_valid_new", 32'(evIf.out_valid), 1);
    chk("t6_data_new", 32'(evIf.out_data), 32'h55);
    drain(1);
    chk("end_scoreboard_empty", 32'(expQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
